control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the Phase 1 datapath. It drives the same control lines the directed benches drive by hand: fetch (T0–T2), then a decoded execute sequence for register-format ALU, multiply/divide and unary instructions. It reads `IR` back from the datapath and emits one-hot register enables plus bus, ALU and memory strobes. It sits beside `datapath` in the CPU top level and replaces the bench state machine.

## Interface
Parameters:
- `PC_RESET`, 32'h0, informational only; the PC reset value is owned by `datapath`.

Ports:
- `clock`  in  1  system clock; all state changes on posedge.
- `clear`  in  1  asynchronous, active-high reset.
- `IR`  in  32  instruction register contents from `datapath`.
- `mem_ready`  in  1  memory read-data-valid handshake.
- `Rin`  out  16  one-hot register load enables, R0..R15.
- `Rout`  out  16  one-hot register bus drives, R0..R15.
- `PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read`  out  1 each  datapath strobes.
- `ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV`  out  1 each  one-hot ALU op select.
- `run`  out  1  high unless halted or in reset.

## Operation
- Instruction fields:
  - opcode `IR[31:27]`, Ra `IR[26:23]`, Rb `IR[22:19]`, Rc `IR[18:15]`.
  - Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
  - Any other opcode executes as nop.
- States: RESET, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are Moore, decoded from state and `IR`.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. T1 holds while `mem_ready`=0; PCin, MDRin and Read stay asserted on each held cycle.
  - T2: MDRout, IRin.
- Binary ops (add through shl):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], op, Zin.
  - T5: Zlowout, Rin[Ra]. Then T0.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Then T0.
- neg/not:
  - T3: Rout[Rb], op, Zin.
  - T4: Zlowout, Rin[Ra]. Then T0.
- nop and unknown opcodes: T2 goes directly to T0.
- halt: T2 goes to HALT. HALT holds with all strobes 0 and `run`=0 until `clear`.

## Timing
- `clear` high forces state to RESET immediately, independent of `clock`, including mid-instruction and mid-T1 wait.
- In RESET, every output is 0, including `run`, `Rin`, `Rout` and all op bits.
- First posedge with `clear` low: RESET goes to T0, and `run` becomes 1.
- At most one bit of `Rout`, and at most one of the bus-drive strobes (PCout, MDRout, Zlowout, Zhighout, and any `Rout` bit), is high in any state.
- At most one ALU op bit is high in any state.
- IncPC is asserted only in T0.
- Cycle counts with `mem_ready` tied high:
  - binary ops: 6 cycles
  - mul/div: 7 cycles
  - neg/not: 5 cycles
  - nop: 3 cycles
- Each cycle of `mem_ready`=0 in T1 adds one cycle.
- `IR` is sampled combinationally. It is stable from T3 onward because IRin is asserted only in T2.
- If Ra = Rb or Ra = Rc, behaviour is unchanged; source values are already latched in Y or Z before Rin[Ra] asserts.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams
  - state encoding (4-bit)
  - IR field bit positions
- Natural sub-module: `reg_select`, a 4-to-16 one-hot decoder. Instantiate it twice, once for `Rin` and once for `Rout`, each with a 4-bit select input and an enable input.

## Test plan
- Reset: assert `clear` asynchronously mid-cycle.
  - All outputs 0 immediately.
  - On release, the next posedge enters T0 with PCout=MARin=IncPC=Zin=1.
- ROL R7,R0,R4 (`IR`=32'h43820000, `mem_ready`=1):
  - T3: Rout=16'h0001 with Yin.
  - T4: Rout=16'h0010 with ROL and Zin.
  - T5: Rin=16'h0080 with Zlowout.
  - Next cycle is T0.
  - Integrated with `datapath` (R0=ABCD1234, R4=8): R7=CD1234AB.
- MUL R3,R1 (opcode 01111, Ra=3, Rb=1):
  - T5: LOin with Zlowout.
  - T6: HIin with Zhighout.
  - Total 7 cycles.
- Fetch stall: hold `mem_ready`=0 for 3 cycles in T1.
  - State stays T1, with Read/MDRin/PCin high throughout.
  - Instruction completes 3 cycles late.
- NOT R5,R2 (opcode 10010):
  - T3: Rout[2], NOT, Zin.
  - T4: Rin[5], Zlowout.
  - Total 5 cycles.
- Opcode 11111 executes as nop, returning to T0 after T2.
- halt (opcode 11011):
  - `run` drops to 0 and all strobes are 0 for 10 cycles.
  - After `clear`, the controller resumes at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, IR field positions, state encoding and decode helpers for control_unit
// Contents:
//   OP_*          5-bit opcode values
//   *_MSB/*_LSB   IR field bit positions
//   state_t       4-bit sequencer state encoding
//   op_class_t    execute-sequence family of an opcode
//   classify()    opcode -> op_class_t (unknown opcodes map to nop)
//   alu_onehot()  opcode -> {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,MUL,DIV}
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_BINARY,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] opcode);
        op_class_t c;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       c = C_BINARY;
            OP_MUL, OP_DIV:                        c = C_MULDIV;
            OP_NEG, OP_NOT:                        c = C_UNARY;
            OP_HALT:                               c = C_HALT;
            default:                               c = C_NOP;
        endcase
        return c;
    endfunction

    function automatic logic [12:0] alu_onehot(input logic [4:0] opcode);
        logic [12:0] sel;
        case (opcode)
            OP_ADD:  sel = 13'b1_0000_0000_0000;
            OP_SUB:  sel = 13'b0_1000_0000_0000;
            OP_AND:  sel = 13'b0_0100_0000_0000;
            OP_OR:   sel = 13'b0_0010_0000_0000;
            OP_SHR:  sel = 13'b0_0001_0000_0000;
            OP_SHRA: sel = 13'b0_0000_1000_0000;
            OP_SHL:  sel = 13'b0_0000_0100_0000;
            OP_ROR:  sel = 13'b0_0000_0010_0000;
            OP_ROL:  sel = 13'b0_0000_0001_0000;
            OP_NEG:  sel = 13'b0_0000_0000_1000;
            OP_NOT:  sel = 13'b0_0000_0000_0100;
            OP_MUL:  sel = 13'b0_0000_0000_0010;
            OP_DIV:  sel = 13'b0_0000_0000_0001;
            default: sel = 13'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_select.sv
// rtl/reg_select.sv - 4-to-16 one-hot register select decoder with enable
// Ports:
//   sel     in  4   register number
//   en      in  1   when low the output is all zeros
//   onehot  out 16  bit[sel] set when en is high
module reg_select (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = 16'h0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute control sequencer for the Phase 1 datapath
// Ports:
//   clock, clear       clock and asynchronous active-high reset
//   IR                 instruction register contents read back from the datapath
//   mem_ready          memory read-data-valid; T1 is held while low
//   Rin, Rout          one-hot register load / bus-drive enables R0..R15
//   PCout..Read        datapath strobes
//   ADD..DIV           one-hot ALU operation select
//   run                high except in RESET and HALT
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        MUL,
    output logic        DIV,
    output logic        run
);

    state_t      state;
    state_t      next_state;
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    op_class_t   cls;
    logic        op_en;
    logic        rin_en;
    logic        rout_en;
    logic [3:0]  rout_sel;

    // PC_RESET belongs to the datapath and IR[14:0] carries no fields used here.
    logic unused_ok;
    assign unused_ok = ^{PC_RESET, IR[RC_LSB-1:0]};

    assign opcode = IR[OPCODE_MSB:OPCODE_LSB];
    assign ra     = IR[RA_MSB:RA_LSB];
    assign rb     = IR[RB_MSB:RB_LSB];
    assign rc     = IR[RC_MSB:RC_LSB];
    assign cls    = classify(opcode);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        run        = 1'b1;
        op_en      = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_sel   = rb;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Read       = 1'b0;

        case (state)
            S_RESET: begin
                run        = 1'b0;
                next_state = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                // Read/MDRin/PCin stay up for every held cycle so the MDR keeps
                // capturing until memory reports valid data.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    next_state = S_T2;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (cls)
                    C_NOP:   next_state = S_T0;
                    C_HALT:  next_state = S_HALT;
                    default: next_state = S_T3;
                endcase
            end
            S_T3: begin
                next_state = S_T4;
                case (cls)
                    C_BINARY: begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                    end
                    C_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        Yin      = 1'b1;
                    end
                    C_UNARY: begin
                        rout_en = 1'b1;
                        op_en   = 1'b1;
                        Zin     = 1'b1;
                    end
                    default: next_state = S_T0;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_BINARY: begin
                        rout_en    = 1'b1;
                        rout_sel   = rc;
                        op_en      = 1'b1;
                        Zin        = 1'b1;
                        next_state = S_T5;
                    end
                    C_MULDIV: begin
                        rout_en    = 1'b1;
                        op_en      = 1'b1;
                        Zin        = 1'b1;
                        next_state = S_T5;
                    end
                    C_UNARY: begin
                        Zlowout    = 1'b1;
                        rin_en     = 1'b1;
                        next_state = S_T0;
                    end
                    default: next_state = S_T0;
                endcase
            end
            S_T5: begin
                Zlowout    = 1'b1;
                next_state = S_T0;
                if (cls == C_MULDIV) begin
                    LOin       = 1'b1;
                    next_state = S_T6;
                end else if (cls == C_BINARY) begin
                    rin_en = 1'b1;
                end else begin
                    Zlowout = 1'b0;
                end
            end
            S_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                next_state = S_T0;
            end
            S_HALT: begin
                run = 1'b0;
            end
            default: begin
                run        = 1'b0;
                next_state = S_RESET;
            end
        endcase
    end

    assign {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV} =
        op_en ? alu_onehot(opcode) : 13'b0;

    reg_select u_rin_sel (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select u_rout_sel (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a per-instruction control-word model
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin, Read;
    logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV;
    logic run;

    control_unit #(.PC_RESET(32'h0)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Read(Read),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .MUL(MUL), .DIV(DIV),
        .run(run)
    );

    always #5 clock = ~clock;

    // Observed control word: [59:44] Rin, [43:28] Rout, [27:14] strobes, [13:1] ALU ops, [0] run
    logic [59:0] outv;
    assign outv = {Rin, Rout,
                   PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
                   Zlowout, Zhighout, HIin, LOin, Read,
                   ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
                   run};

    localparam logic [13:0] M_PCOUT = 14'h2000, M_PCIN  = 14'h1000, M_INCPC = 14'h0800;
    localparam logic [13:0] M_MARIN = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100;
    localparam logic [13:0] M_IRIN  = 14'h0080, M_YIN   = 14'h0040, M_ZIN   = 14'h0020;
    localparam logic [13:0] M_ZLO   = 14'h0010, M_ZHI   = 14'h0008, M_HIIN  = 14'h0004;
    localparam logic [13:0] M_LOIN  = 14'h0002, M_READ  = 14'h0001;

    int vectors = 0;
    int miscompares = 0;

    logic [59:0] exp_q[$];
    bit          mr_q[$];
    logic [59:0] obs_q[$];

    function automatic logic [59:0] word(input logic [15:0] rin, input logic [15:0] rout,
                                         input logic [13:0] s, input logic [12:0] o);
        return {rin, rout, s, o, 1'b1};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] r);
        return 16'(1) << r;
    endfunction

    // ALU select bit position in {ADD..DIV}, -1 when the opcode uses no ALU op.
    function automatic int op_bit(input int opc);
        case (opc)
            3: return 12;  4: return 11;  5: return 10;  6: return 9;
            7: return 5;   8: return 4;   9: return 8;   10: return 7;
            11: return 6;  15: return 1;  16: return 0;  17: return 3;
            18: return 2;
            default: return -1;
        endcase
    endfunction

    // Expected per-cycle control words for one instruction starting in T0.
    task automatic build(input logic [31:0] ir, input int stalls);
        int opc;
        logic [3:0] ra, rb, rc;
        logic [12:0] op;
        opc = int'(ir[31:27]);
        ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        op = (op_bit(opc) >= 0) ? (13'(1) << op_bit(opc)) : 13'b0;
        exp_q.delete(); mr_q.delete();
        exp_q.push_back(word(0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0));
        mr_q.push_back(1'($urandom));
        for (int i = 0; i <= stalls; i++) begin
            exp_q.push_back(word(0, 0, M_ZLO | M_PCIN | M_READ | M_MDRIN, 0));
            mr_q.push_back(i == stalls);
        end
        exp_q.push_back(word(0, 0, M_MDROUT | M_IRIN, 0));
        mr_q.push_back(1'($urandom));
        if (opc >= 3 && opc <= 11) begin
            exp_q.push_back(word(0, oh(rb), M_YIN, 0));
            exp_q.push_back(word(0, oh(rc), M_ZIN, op));
            exp_q.push_back(word(oh(ra), 0, M_ZLO, 0));
        end else if (opc == 15 || opc == 16) begin
            exp_q.push_back(word(0, oh(ra), M_YIN, 0));
            exp_q.push_back(word(0, oh(rb), M_ZIN, op));
            exp_q.push_back(word(0, 0, M_ZLO | M_LOIN, 0));
            exp_q.push_back(word(0, 0, M_ZHI | M_HIIN, 0));
        end else if (opc == 17 || opc == 18) begin
            exp_q.push_back(word(0, oh(rb), M_ZIN, op));
            exp_q.push_back(word(oh(ra), 0, M_ZLO, 0));
        end
        while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom));
    endtask

    // Called at a negedge with the DUT in T0.
    task automatic exec_instr(input string name, input logic [31:0] ir, input int stalls);
        build(ir, stalls);
        obs_q.delete();
        IR = ir;
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (outv !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s ir=%h cycle %0d: got %h expected %h", name, ir, k, outv, exp_q[k]);
            end
            obs_q.push_back(outv);
            mem_ready = mr_q[k];
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic check_word(input string name, input logic [59:0] expv);
        vectors++;
        if (outv !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, outv, expv);
        end
    endtask

    task automatic test_reset;
        clear = 1'b1; IR = 32'h0; mem_ready = 1'b0;
        @(negedge clock);
        check_word("reset_hold", 60'h0);
        clear = 1'b0;
        @(posedge clock); @(negedge clock);
        check_word("reset_release_t0", word(0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0));
        // advance into the execute phase of an add, then clear asynchronously mid-cycle
        IR = {5'b00011, 4'd1, 4'd2, 4'd3, 15'h0};
        mem_ready = 1'b1;
        repeat (4) begin @(posedge clock); @(negedge clock); end
        #2 clear = 1'b1;
        #1 check_word("reset_async_mid_instr", 60'h0);
        @(negedge clock);
        check_word("reset_held_across_edge", 60'h0);
        // clear during a T1 wait
        #2 clear = 1'b0;
        @(negedge clock);
        mem_ready = 1'b0;
        @(posedge clock); @(negedge clock);
        check_word("reset_pre_t1_wait", word(0, 0, M_ZLO | M_PCIN | M_READ | M_MDRIN, 0));
        #2 clear = 1'b1;
        #1 check_word("reset_async_in_t1", 60'h0);
        @(negedge clock);
        #2 clear = 1'b0;
        @(negedge clock);
        check_word("reset_resume_t0", word(0, 0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0));
    endtask

    task automatic test_rol;
        exec_instr("rol", 32'h43820000, 0);
        vectors++;
        if (obs_q[3][43:28] !== 16'h0001 || obs_q[3][20] !== 1'b1) begin
            miscompares++;
            $display("FAIL rol_t3: got Rout=%h Yin=%b expected 0001 1", obs_q[3][43:28], obs_q[3][20]);
        end
        vectors++;
        if (obs_q[4][43:28] !== 16'h0010 || obs_q[4][13:1] !== 13'h0010) begin
            miscompares++;
            $display("FAIL rol_t4: got Rout=%h ops=%h expected 0010 0010", obs_q[4][43:28], obs_q[4][13:1]);
        end
        vectors++;
        if (obs_q[5][59:44] !== 16'h0080 || obs_q[5][18] !== 1'b1) begin
            miscompares++;
            $display("FAIL rol_t5: got Rin=%h Zlowout=%b expected 0080 1", obs_q[5][59:44], obs_q[5][18]);
        end
    endtask

    task automatic test_muldiv;
        exec_instr("mul", {5'b01111, 4'd3, 4'd1, 4'd0, 15'h0}, 0);
        vectors++;
        if (obs_q.size() != 7 || obs_q[5][15] !== 1'b1 || obs_q[6][16] !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_lo_hi: got LOin=%b HIin=%b expected 1 1", obs_q[5][15], obs_q[6][16]);
        end
        exec_instr("div", {5'b10000, 4'd9, 4'd14, 4'd6, 15'h1234}, 0);
    endtask

    task automatic test_stall;
        exec_instr("stall3", {5'b00100, 4'd2, 4'd5, 4'd11, 15'h0}, 3);
    endtask

    task automatic test_unary;
        exec_instr("not", {5'b10010, 4'd5, 4'd2, 4'd0, 15'h0}, 0);
        exec_instr("neg", {5'b10001, 4'd15, 4'd15, 4'd7, 15'h7fff}, 1);
    endtask

    task automatic test_nop;
        exec_instr("unknown", {5'b11111, 27'h5a5a5a5}, 0);
        exec_instr("nop", {5'b11010, 27'h0}, 2);
    endtask

    task automatic test_random;
        logic [31:0] ir;
        for (int n = 0; n < 60; n++) begin
            ir = $urandom;
            if (ir[31:27] == 5'b11011) ir[31:27] = 5'b11010;
            exec_instr("random", ir, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 16; r++) begin
            exec_instr("b2b_add", {5'b00011, 4'(r), 4'(r), 4'(15 - r), 15'h0}, 0);
        end
    endtask

    task automatic test_halt;
        logic [31:0] ir;
        ir = {5'b11011, 27'h0};
        exec_instr("halt_fetch", ir, 1);
        for (int c = 0; c < 10; c++) begin
            check_word("halt_idle", 60'h0);
            mem_ready = 1'($urandom);
            @(posedge clock); @(negedge clock);
        end
        #2 clear = 1'b1;
        #1 check_word("halt_clear", 60'h0);
        @(negedge clock);
        #2 clear = 1'b0;
        @(negedge clock);
        exec_instr("after_halt", {5'b00101, 4'd4, 4'd8, 4'd12, 15'h0}, 0);
        exec_instr("final_nop", {5'b11010, 27'h0}, 0);
    endtask

    initial begin
        test_reset();
        test_rol();
        test_muldiv();
        test_stall();
        test_unary();
        test_nop();
        test_back_to_back();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
